data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words of storage (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning the extra wait cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, MA-stage access request.
REQ-006 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-010 SHALL have port req_size, input, 2, 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-011 SHALL have port req_unsigned, input, 1, zero-extend load when 1, sign-extend when 0.
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle response pulse.
REQ-013 SHALL have port rsp_rdata, output, 32, extended load data; 0 for stores.
REQ-014 SHALL have port rsp_err, output, 1, access faulted; qualified by rsp_valid.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request when req_valid && req_ready, registering we/addr/wdata/size/unsigned; inputs are don't-care afterwards.
REQ-017 SHALL go from IDLE to RESP directly when WAIT_CYCLES = 0, else to WAIT with a counter loaded to WAIT_CYCLES-1, counting down to 0.
REQ-018 SHALL commit a store and sample load data on the transition into RESP, never earlier.
REQ-019 SHALL assert rsp_valid exactly one cycle in RESP; a request accepted at edge T yields rsp_valid during cycle T+1+WAIT_CYCLES.
REQ-020 SHALL have no response backpressure; the next request is accepted no earlier than the cycle after RESP (throughput 1 per 2+WAIT_CYCLES cycles).
REQ-021 SHALL write stores by byte lane: byte to lane addr[1:0], half to lanes addr[1]*2..+1, word to all lanes; other lanes unchanged.
REQ-022 SHALL return loads as the selected lane(s) shifted to bit 0, then sign- or zero-extended per req_unsigned; word loads pass through.
REQ-023 SHALL index storage with addr[log2(DEPTH_WORDS)+1:2].
REQ-024 SHALL perform store-then-load to the same address in back-to-back transactions returning the newly stored data.

Reset
REQ-025 SHALL drive req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state = IDLE, counter = 0 while reset is high; req_ready = 1 in the first cycle after reset deasserts.
REQ-026 SHALL abort an in-flight transaction when reset is asserted in WAIT or RESP; an uncommitted store SHALL NOT write memory and no response SHALL be issued.
REQ-027 SHALL NOT clear storage contents on reset.

Configuration
REQ-028 SHALL use macro DMEM_ACCESS_ERR_EN: when defined, misaligned (half with addr[0]=1, word with addr[1:0]!=0), req_size = 11, or word index >= DEPTH_WORDS raises rsp_err = 1 with rsp_rdata = 0 and suppresses the store.
REQ-029 SHALL, when DMEM_ACCESS_ERR_EN is undefined, tie rsp_err to 0, force-align addresses by ignoring the offending low bits, treat size 11 as word, and wrap out-of-range addresses modulo DEPTH_WORDS.

Structure
REQ-030 SHALL place the access-size enum (BYTE/HALF/WORD/RSVD), the FSM state enum, and default DEPTH_WORDS/WAIT_CYCLES constants in shared package dmem_pkg.
REQ-031 SHALL use sub-module dmem_array: a synchronous-write, 4-byte-enable word RAM; the FSM, lane steering and extension stay in data_mem_responder.

Verification
REQ-032 SHALL cover: WAIT_CYCLES=1, store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF.
REQ-033 SHALL cover: store byte 0x80 @0x13 over 0x11223344, then load byte signed @0x13 -> 0xFFFFFF80; load unsigned -> 0x00000080; load word -> 0x80223344.
REQ-034 SHALL cover: store half 0xABCD @0x22, then load half signed @0x22 -> 0xFFFFABCD; load half unsigned -> 0x0000ABCD.
REQ-035 SHALL cover: store word 0x12345678 @0x40 with reset pulsed in WAIT, then load @0x40 -> old contents, no rsp_valid for the aborted access.
REQ-036 SHALL cover: with DMEM_ACCESS_ERR_EN, load word @0x41 -> rsp_err 1, rdata 0; without it -> rsp_err 0, data of word @0x40.
REQ-037 SHALL cover: WAIT_CYCLES=0, req_valid held high -> accepts every 2nd cycle, req_ready low during RESP.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory responder.
//   size_e  : access size encoding carried on req_size
//   state_e : responder handshake states
//   extend_load : right-aligned lane data -> sign/zero extended load value
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 1;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned DATA_W              = 32;

  // Extend the low byte/half of an already shifted word; anything wider passes through.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] lanes,
                                                    input size_e             sz,
                                                    input logic              uns);
    logic [DATA_W-1:0] res;
    case (sz)
      SIZE_BYTE: res = {{24{~uns & lanes[7]}}, lanes[7:0]};
      SIZE_HALF: res = {{16{~uns & lanes[15]}}, lanes[15:0]};
      default:   res = lanes;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM with per-byte write enables.
// Write is synchronous on the rising edge; read is combinational so the
// responder can sample data on the same edge it commits a store.
// Ports:
//   clk      : clock
//   we_i     : write strobe
//   be_i     : byte-lane enables (bit n -> bits 8n+7:8n)
//   addr_i   : word index
//   wdata_i  : lane-replicated write data
//   rdata_o  : word at addr_i
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] merged_d;

  assign rdata_o = mem_q[addr_i];

  // Byte-enable merge so each write is a single whole-word update.
  always_comb begin
    merged_d = rdata_o;
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) merged_d[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= merged_d;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder for the MA stage: accepts one load/store at a time,
// waits WAIT_CYCLES, then pulses a single-cycle response.
// Optional feature macro: DMEM_ACCESS_ERR_EN -- flags misaligned, reserved-size
// and out-of-range accesses via rsp_err (store suppressed, rdata 0). Without it
// addresses are force-aligned, size 11 acts as word and indices wrap.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_we            : 1 = store, 0 = load
//   req_addr          : byte address
//   req_wdata         : right-aligned store data
//   req_size          : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned      : zero-extend loads when 1
//   rsp_valid         : one-cycle response pulse
//   rsp_rdata         : extended load data, 0 for stores/errors
//   rsp_err           : access fault, qualified by rsp_valid
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam bit          NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    NO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_err_q;

  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [1:0]         size_q;
  logic               uns_q;

  logic               accept;
  logic               acc_we;
  logic [31:0]        acc_addr;
  logic [31:0]        acc_wdata;
  size_e              acc_size;
  logic               acc_uns;
  logic               acc_err;
  logic [1:0]         lane_off;
  logic [3:0]         be;
  logic [31:0]        wlanes;
  logic [31:0]        rd_word;
  logic [31:0]        load_data_d;
  logic               mem_we;

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign accept = req_valid & ready_q;

  // Operands of the access being committed: live inputs when IDLE goes straight
  // to RESP, captured copies once the request has been parked in WAIT.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_size  = size_e'(size_q);
    acc_uns   = uns_q;
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_size  = size_e'(req_size);
      acc_uns   = req_unsigned;
    end
`ifndef DMEM_ACCESS_ERR_EN
    if (acc_size == SIZE_RSVD) acc_size = SIZE_WORD;
`endif
  end

`ifdef DMEM_ACCESS_ERR_EN
  // Fault on reserved size, misalignment or word index beyond the array.
  always_comb begin
    acc_err = 1'b0;
    case (acc_size)
      SIZE_HALF: acc_err = acc_addr[0];
      SIZE_WORD: acc_err = |acc_addr[1:0];
      SIZE_RSVD: acc_err = 1'b1;
      default:   acc_err = 1'b0;
    endcase
    if (|acc_addr[31:AW+2]) acc_err = 1'b1;
  end
`else
  logic unused_addr_hi;
  assign acc_err        = 1'b0;
  assign unused_addr_hi = ^acc_addr[31:AW+2];
`endif

  // Lane placement; low address bits below the access size are ignored.
  always_comb begin
    lane_off = acc_addr[1:0];
    be       = 4'b1111;
    wlanes   = acc_wdata;
    case (acc_size)
      SIZE_BYTE: begin
        be     = 4'b0001 << acc_addr[1:0];
        wlanes = {4{acc_wdata[7:0]}};
      end
      SIZE_HALF: begin
        lane_off = {acc_addr[1], 1'b0};
        be       = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{acc_wdata[15:0]}};
      end
      default: lane_off = 2'b00;
    endcase
  end

  always_comb begin
    load_data_d = '0;
    if (!acc_we && !acc_err) begin
      load_data_d = extend_load(rd_word >> {lane_off, 3'b000}, acc_size, acc_uns);
    end
  end

  // Memory is touched only on the edge entering RESP, and never under reset.
  assign mem_we = ~reset & acc_we & ~acc_err &
                  (((state_q == ST_IDLE) & accept & NO_WAIT) |
                   ((state_q == ST_WAIT) & (cnt_q == '0)));

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (be),
    .addr_i  (acc_addr[AW+1:2]),
    .wdata_i (wlanes),
    .rdata_o (rd_word)
  );

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            ready_q <= 1'b0;
            if (NO_WAIT) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= load_data_d;
              rsp_err_q   <= acc_err;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_data_d;
            rsp_err_q   <= acc_err;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic
// against a byte-addressed reference memory. Instance A uses WAIT_CYCLES=1,
// instance B uses WAIT_CYCLES=0 for the back-to-back throughput check.
module tb_data_mem_responder;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned WAIT_A = 1;
  localparam int unsigned NWORDS = 64;

  logic        clk;
  logic        reset;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;

  logic        a_valid, a_ready, a_rsp_valid, a_err;
  logic [31:0] a_rdata;
  logic        b_valid, b_ready, b_rsp_valid, b_err;
  logic [31:0] b_rdata;

  int n_cmp;
  int n_bad;

  logic [7:0] ref_bytes [0:4*DEPTH-1];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as bytes, access = nb consecutive bytes at an aligned base.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns,
                       output logic [31:0] rd, output logic err);
    int nb, idx, off, ba;
    logic [31:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = 1'b0;
`ifdef DMEM_ACCESS_ERR_EN
    err = (sz == 2'd3) || ((addr % nb) != 0) || ((addr / 4) >= DEPTH);
`endif
    idx = int'((addr / 4) % DEPTH);
    off = (int'(addr % 4) / nb) * nb;
    ba  = idx * 4 + off;
    rd  = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_bytes[ba + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_bytes[ba + i];
        if (!uns && nb < 4 && v[8*nb - 1]) begin
          for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        rd = v;
      end
    end
  endtask

  // One full transaction on instance A, checked against the model.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] sz, input logic uns,
                      output logic [31:0] rd_o, output logic err_o);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          guard;
    int          lat;
    model(we, addr, wd, sz, uns, exp_rd, exp_err);
    rd_o  = '0;
    err_o = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    guard = 0;
    while (!a_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!a_ready) begin
      check("accept_timeout", 32'(a_ready), 32'd1);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    a_valid      = 1'b0;
    req_we       = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    if (WAIT_A != 0) check("ready_busy", 32'(a_ready), 32'd0);
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(WAIT_A));
    rd_o  = a_rdata;
    err_o = a_err;
    check("rdata", a_rdata, exp_rd);
    check("err", 32'(a_err), 32'(exp_err));
    @(posedge clk); #1;
    check("pulse_width", 32'(a_rsp_valid), 32'd0);
    check("ready_back", 32'(a_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] addr;
    logic        seen;

    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = 2'd2; req_unsigned = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_ready_b", 32'(b_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(a_ready), 32'd1);

    // Word store then load at 0x10
    xact(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, rd, er);
    check("st_word_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er);
    check("ld_word", rd, 32'hDEADBEEF);

    // Byte store over a known word
    xact(1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0, rd, er);
    xact(1'b1, 32'h13, 32'h00000080, 2'd0, 1'b0, rd, er);
    xact(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, rd, er);
    check("ld_byte_s", rd, 32'hFFFFFF80);
    xact(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, rd, er);
    check("ld_byte_u", rd, 32'h00000080);
    xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er);
    check("ld_word_merged", rd, 32'h80223344);

    // Half store and extension
    xact(1'b1, 32'h20, 32'h0, 2'd2, 1'b0, rd, er);
    xact(1'b1, 32'h22, 32'h0000ABCD, 2'd1, 1'b0, rd, er);
    xact(1'b0, 32'h22, 32'h0, 2'd1, 1'b0, rd, er);
    check("ld_half_s", rd, 32'hFFFFABCD);
    xact(1'b0, 32'h22, 32'h0, 2'd1, 1'b1, rd, er);
    check("ld_half_u", rd, 32'h0000ABCD);

    // Store aborted by reset while in WAIT
    xact(1'b1, 32'h40, 32'hCAFEF00D, 2'd2, 1'b0, rd, er);
    @(negedge clk);
    a_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678;
    req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("abort_in_wait", 32'(a_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_rst_ready", 32'(a_ready), 32'd0);
    seen = a_rsp_valid;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen = seen | a_rsp_valid;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    xact(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, rd, er);
    check("abort_old_data", rd, 32'hCAFEF00D);

    // Misaligned word load
    xact(1'b0, 32'h41, 32'h0, 2'd2, 1'b0, rd, er);
`ifdef DMEM_ACCESS_ERR_EN
    check("misalign_rdata", rd, 32'd0);
    check("misalign_err", 32'(er), 32'd1);
`else
    check("misalign_rdata", rd, 32'hCAFEF00D);
    check("misalign_err", 32'(er), 32'd0);
`endif

    // Back-to-back with WAIT_CYCLES=0 and valid held high
    @(negedge clk);
    b_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hA5A50F0F;
    req_size = 2'd2; req_unsigned = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("b2b_ready", 32'(b_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("b2b_rsp", 32'(b_rsp_valid), (i % 2 == 0) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    b_valid = 1'b0;
    @(negedge clk);
    b_valid = 1'b1; req_we = 1'b0;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("b_lat0_valid", 32'(b_rsp_valid), 32'd1);
    check("b_lat0_rdata", b_rdata, 32'hA5A50F0F);
    check("b_lat0_err", 32'(b_err), 32'd0);
    @(posedge clk); #1;
    check("b_pulse", 32'(b_rsp_valid), 32'd0);

    // Prefill a window, then random traffic
    for (int w = 0; w < NWORDS; w++) begin
      xact(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, rd, er);
    end
    for (int t = 0; t < 200; t++) begin
      addr = 32'($urandom_range(0, NWORDS * 4 - 1));
      if ($urandom_range(0, 7) == 0) addr = addr | (32'd1 << $urandom_range(12, 31));
      xact(1'($urandom), addr, $urandom, 2'($urandom), 1'($urandom), rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
